// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: movement directions and push-button indices.
// Key indices line up with direction codes, so a key index is also its direction.
package snake_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam int KEY_RIGHT = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_LEFT  = 3;

  function automatic logic [1:0] dir_reverse(input logic [1:0] d);
    return d ^ 2'b11;
  endfunction

  function automatic logic [3:0] dir_onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, stability counter, debounced level, press pulse.
// press is a one-cycle pulse on the edge the debounced level becomes pressed.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  logic [1:0]       sync;
  logic             level_n;
  logic [CNT_W-1:0] cnt;
  logic             sample_n;

  assign sample_n = sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], key_n};
    end
  end

  // The counter tracks consecutive samples that disagree with the debounced level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_n <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sample_n == level_n) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_n <= sample_n;
        cnt     <= '0;
        press   <= ~sample_n;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/direction_input.sv
// Turns four raw active-low buttons into a registered one-hot snake direction.
// Turns are validated against the committed direction and committed only on move_tick.
module direction_input
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] key_n,
  input  logic       move_tick,
  output logic [1:0] dir,
  output logic       move_right,
  output logic       move_down,
  output logic       move_up,
  output logic       move_left,
  output logic       turn_pending,
  output logic       key_event
);

  logic [3:0] press;
  logic [3:0] move_oh;
  logic [1:0] pend_dir;
  logic [1:0] req_dir;
  logic [1:0] commit_dir;
  logic       req_vld;
  logic       accept;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key (
      .clk    (clk),
      .reset_n(reset_n),
      .key_n  (key_n[k]),
      .press  (press[k])
    );
  end

  // A pending turn commits first; a same-cycle request is judged against the result.
  always_comb begin
    req_vld    = |press;
    req_dir    = DIR_RIGHT;
    commit_dir = (move_tick && turn_pending) ? pend_dir : dir;
    if (press[KEY_UP]) begin
      req_dir = DIR_UP;
    end else if (press[KEY_DOWN]) begin
      req_dir = DIR_DOWN;
    end else if (press[KEY_LEFT]) begin
      req_dir = DIR_LEFT;
    end
    accept = req_vld && (req_dir != commit_dir) && (req_dir != dir_reverse(commit_dir));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir          <= DIR_RIGHT;
      move_oh      <= 4'b0001;
      pend_dir     <= DIR_RIGHT;
      turn_pending <= 1'b0;
      key_event    <= 1'b0;
    end else begin
      dir       <= commit_dir;
      move_oh   <= dir_onehot(commit_dir);
      key_event <= req_vld;
      if (accept) begin
        pend_dir     <= req_dir;
        turn_pending <= 1'b1;
      end else if (move_tick) begin
        turn_pending <= 1'b0;
      end
    end
  end

  assign move_right = move_oh[DIR_RIGHT];
  assign move_down  = move_oh[DIR_DOWN];
  assign move_up    = move_oh[DIR_UP];
  assign move_left  = move_oh[DIR_LEFT];

endmodule

// File: tb/tb_direction_input.sv
// Bench for direction_input with DEBOUNCE_CYCLES=4: directed scenarios plus random key/tick traffic.
module tb_direction_input;

  localparam int D  = 4;
  localparam int HW = D + 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic       move_tick = 1'b0;
  logic [1:0] dir;
  logic       move_right, move_down, move_up, move_left;
  logic       turn_pending, key_event;

  int checks = 0;
  int errors = 0;
  int step_no = 0;
  int ev_cnt = 0;
  int last_ev_step = -1;

  // Reference: raw sample history per key, debounced levels, game state.
  logic [HW-1:0] m_raw [4];
  logic [3:0]    m_lvl;
  logic [3:0]    m_pp;
  logic [1:0]    m_dir, m_pend;
  logic          m_pv, m_kev;
  int            prio [4] = '{2, 1, 3, 0};

  direction_input #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_n       (key_n),
    .move_tick   (move_tick),
    .dir         (dir),
    .move_right  (move_right),
    .move_down   (move_down),
    .move_up     (move_up),
    .move_left   (move_left),
    .turn_pending(turn_pending),
    .key_event   (key_event)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_raw[k] = '1;
    m_lvl = 4'hF; m_pp = 4'h0; m_dir = 2'd0; m_pend = 2'd0; m_pv = 1'b0; m_kev = 1'b0;
  endtask

  // A key flips once the last D samples past the 2-deep synchronizer all disagree with it.
  task automatic model_edge();
    logic [3:0] pnow;
    logic       all_diff;
    logic [1:0] commit, req;
    pnow = 4'h0;
    for (int k = 0; k < 4; k++) begin
      m_raw[k] = {m_raw[k][HW-2:0], key_n[k]};
      all_diff = 1'b1;
      for (int j = 2; j < HW; j++) if (m_raw[k][j] == m_lvl[k]) all_diff = 1'b0;
      if (all_diff) begin
        m_lvl[k] = ~m_lvl[k];
        if (m_lvl[k] == 1'b0) pnow[k] = 1'b1;
      end
    end
    commit = m_dir;
    if (move_tick && m_pv) begin
      commit = m_pend;
      m_pv = 1'b0;
    end
    if (m_pp != 4'h0) begin
      req = 2'd0;
      for (int i = 3; i >= 0; i--) if (m_pp[prio[i]]) req = 2'(prio[i]);
      if (int'(req) != int'(commit) && int'(req) != 3 - int'(commit)) begin
        m_pend = req;
        m_pv = 1'b1;
      end
    end
    m_dir = commit;
    m_kev = (m_pp != 4'h0);
    m_pp  = pnow;
  endtask

  task automatic chk_outputs();
    chk("dir", 8'(dir), 8'(m_dir));
    chk("move_onehot", 8'({move_left, move_up, move_down, move_right}), 8'(4'b0001 << m_dir));
    chk("turn_pending", 8'(turn_pending), 8'(m_pv));
    chk("key_event", 8'(key_event), 8'(m_kev));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    step_no++;
    if (key_event) begin
      ev_cnt++;
      last_ev_step = step_no;
    end
    chk_outputs();
  endtask

  task automatic do_reset();
    key_n = 4'hF;
    move_tick = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_dir", 8'(dir), 8'd0);
    chk("async_rst_move", 8'({move_left, move_up, move_down, move_right}), 8'h1);
    chk("async_rst_pending", 8'(turn_pending), 8'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic tick();
    move_tick = 1'b1;
    step();
    move_tick = 1'b0;
  endtask

  // Hold the keys in mask for 'hold' steps (tick on step tick_at, -1 for none), then release.
  task automatic press(input logic [3:0] mask, input int hold, input int tick_at);
    for (int i = 0; i < hold; i++) begin
      key_n = ~mask;
      move_tick = (i == tick_at);
      step();
    end
    key_n = 4'hF;
    move_tick = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    int ev0, first_low;
    logic [3:0] mask;
    #2;
    do_reset();

    // Idle ticks leave the direction alone.
    repeat (3) step();
    repeat (3) tick();
    chk("idle_dir", 8'(dir), 8'd0);

    // Glitch shorter than the debounce window is invisible.
    ev0 = ev_cnt;
    press(4'b0100, 3, -1);
    repeat (4) step();
    chk("glitch_events", 8'(ev_cnt - ev0), 8'd0);

    // Long press of up: one event, 6 edges after the first low sample.
    ev0 = ev_cnt;
    first_low = step_no + 1;
    press(4'b0100, 20, -1);
    chk("press_events", 8'(ev_cnt - ev0), 8'd1);
    chk("press_latency", 8'(last_ev_step - first_low), 8'd6);
    chk("press_pending", 8'(turn_pending), 8'd1);
    tick();
    chk("up_dir", 8'(dir), 8'd2);
    chk("up_move", 8'(move_up), 8'd1);

    // Reverse rejection: left while moving right, down while moving up.
    do_reset();
    press(4'b1000, 8, -1);
    chk("rev_left_pending", 8'(turn_pending), 8'd0);
    tick();
    chk("rev_left_dir", 8'(dir), 8'd0);
    press(4'b0100, 8, -1);
    tick();
    press(4'b0010, 8, -1);
    chk("rev_down_pending", 8'(turn_pending), 8'd0);
    tick();
    chk("rev_down_dir", 8'(dir), 8'd2);

    // Requests judged against committed dir; last valid press wins.
    do_reset();
    press(4'b0100, 8, -1);
    press(4'b1000, 8, -1);
    press(4'b0010, 8, -1);
    tick();
    chk("overwrite_dir", 8'(dir), 8'd1);

    // Debounced left edge reaches the turn logic on the same edge as move_tick.
    do_reset();
    press(4'b0100, 8, -1);
    press(4'b1000, 10, 6);
    chk("same_cycle_dir", 8'(dir), 8'd2);
    chk("same_cycle_pending", 8'(turn_pending), 8'd1);
    tick();
    chk("same_cycle_next", 8'(dir), 8'd3);

    // Simultaneous up+down: only up taken; then reset with left pending.
    do_reset();
    press(4'b0110, 8, -1);
    tick();
    chk("simul_dir", 8'(dir), 8'd2);
    press(4'b1000, 8, -1);
    chk("left_pending", 8'(turn_pending), 8'd1);
    do_reset();
    step();

    // Random key patterns and ticks against the model.
    for (int s = 0; s < 60; s++) begin
      mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      for (int i = 0, n = $urandom_range(1, 10); i < n; i++) begin
        key_n = ~mask;
        move_tick = ($urandom_range(0, 3) == 0);
        step();
      end
      for (int i = 0, n = $urandom_range(1, 8); i < n; i++) begin
        key_n = 4'hF;
        move_tick = ($urandom_range(0, 2) == 0);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
